// File: rtl/fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Shares one output link between N synchronous input FIFOs. Arbitration is
// round-robin with wormhole locking: the winning input owns the link until
// its tail flit has been read. Read data returns one cycle after the read
// strobe and is captured into a 2-entry output buffer that drives a
// valid/ready link. A read is only issued when the buffer is guaranteed to
// have room for the returning flit, so the buffer never overflows.
//
// Ports:
//   clk_i     in   1        clock
//   rst_i     in   1        reset, asynchronous, active-low
//   empty_i   in   N        per-FIFO empty flags
//   read_o    out  N        per-FIFO read strobes (at most one bit high)
//   data_i    in   N*WIDTH  FIFO read data, slice k = [k*WIDTH +: WIDTH]
//   data_o    out  WIDTH    head flit of the output buffer
//   valid_o   out  1        data_o valid
//   ready_i   in   1        link accepts the flit when valid_o & ready_i
//   grant_o   out  N        one-hot current owner, 0 when idle
//   err_o     out  1        sticky watchdog error
//
// Optional feature macro: ARB_WATCHDOG_EN
//   Defined:     a stall counter runs while the owner is empty mid-packet;
//                err_o latches high once it reaches WDOG_CYCLES.
//   Not defined: no counter, err_o is tied to 0.
// ---------------------------------------------------------------------------
module fifo_drain_arbiter #(
  parameter int N           = 4,
  parameter int WIDTH       = 32,
  parameter int TAIL_BIT    = 31,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       empty_i,
  output logic [N-1:0]       read_o,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [N-1:0]       grant_o,
  output logic               err_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Reject parameter sets the datapath cannot represent.
  if (N < 2 || N > 16 || TAIL_BIT < 0 || TAIL_BIT >= WIDTH || WDOG_CYCLES < 1) begin : g_bad_params
    $error("fifo_drain_arbiter: unsupported parameter set");
  end

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [WIDTH-1:0] data_arr [N];
  logic [WIDTH-1:0] owner_flit;
  logic             tail_in_flight;
  logic             pop;
  logic [2:0]       used;
  logic             slot_free;
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [SUM_W-1:0] cand;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_slice
    assign data_arr[gi] = data_i[gi*WIDTH +: WIDTH];
  end

  // A flit in flight always belongs to the current owner: reads are only
  // issued in the owner's name, and the owner changes only in ARB, where
  // nothing is in flight.
  assign owner_flit     = data_arr[owner_q];
  assign tail_in_flight = inflight_q & owner_flit[TAIL_BIT];

  assign valid_o = (count_q != 2'd0);
  assign data_o  = buf_q[rd_ptr_q];
  assign pop     = valid_o & ready_i;

  // Credit: stored flits plus the one returning, minus the one leaving now.
  assign used      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign slot_free = (used < 3'd2);

  // Round-robin search starting at rr_q, wrapping modulo N.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_q} + SUM_W'(i);
      if (cand >= SUM_W'(N)) cand = cand - SUM_W'(N);
      if (!arb_found && !empty_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ARB;
      owner_q    <= '0;
      rr_q       <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    inflight_d = rd_en;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
    case (state_q)
      ARB: begin
        if (rd_en) begin
          state_d = LOCK;
          owner_d = rd_idx;
        end
      end
      LOCK: begin
        if (tail_in_flight) begin
          state_d = ARB;
          rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        end
      end
    endcase
    if (inflight_q) begin
      buf_d[wr_ptr_q] = owner_flit;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // Output logic. Strobes and grant are combinational from state, so they
  // are forced low while reset is held to make reset take effect at once.
  always_comb begin
    rd_en   = 1'b0;
    rd_idx  = owner_q;
    read_o  = '0;
    grant_o = '0;
    case (state_q)
      ARB: begin
        if (arb_found && slot_free) begin
          rd_en            = 1'b1;
          rd_idx           = arb_idx;
          grant_o[arb_idx] = 1'b1;
        end
      end
      LOCK: begin
        grant_o[owner_q] = 1'b1;
        if (!tail_in_flight && !empty_i[owner_q] && slot_free) rd_en = 1'b1;
      end
    endcase
    if (rd_en) read_o[rd_idx] = 1'b1;
    if (!rst_i) begin
      read_o  = '0;
      grant_o = '0;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_CYCLES);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  // Counts only true stalls: owner empty with nothing returning. Saturates
  // at the limit so the error stays latched without wrapping.
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q != LOCK || rd_en) begin
      wdog_d = '0;
    end else if (empty_i[owner_q] && !inflight_q && wdog_q != WD_LIMIT) begin
      wdog_d = wdog_q + WD_W'(1);
    end
    if (wdog_d == WD_LIMIT) err_d = 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_drain_arbiter. Input FIFOs are modelled as small arrays;
// each test pushes the flits it expects on the link, in the order the
// arbitration rules require, into a scoreboard queue that is popped and
// compared whenever the link transfers a flit. Per-cycle read/grant/valid
// histories are checked against the expected cycle patterns.
// ---------------------------------------------------------------------------
module tb_fifo_drain_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TB = 31;
  localparam int WD = 8;
  localparam int FD = 32;

`ifdef ARB_WATCHDOG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   empty_i;
  logic [N-1:0]   read_o;
  logic [N*W-1:0] data_i;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           ready_i;
  logic [N-1:0]   grant_o;
  logic           err_o;

  always #5 clk_i = ~clk_i;

  fifo_drain_arbiter #(
    .N(N), .WIDTH(W), .TAIL_BIT(TB), .WDOG_CYCLES(WD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .empty_i(empty_i), .read_o(read_o),
    .data_i(data_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  logic [W-1:0]   fmem [N][FD];
  int             fhead [N];
  int             ftail [N];
  logic [W-1:0]   exp_q [$];
  logic [N-1:0]   rd_log [$];
  logic [N-1:0]   gnt_log [$];
  logic           vld_log [$];
  int             checks = 0;
  int             failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_flit(input int src, input int seq, input bit tail);
    logic [W-1:0] f;
    f        = '0;
    f[TB]    = tail;
    f[23:16] = 8'(src);
    f[15:0]  = 16'(seq);
    return f;
  endfunction

  task automatic update_empty();
    for (int k = 0; k < N; k++) empty_i[k] = (fhead[k] == ftail[k]);
  endtask

  task automatic load_flit(input int src, input int seq, input bit tail);
    fmem[src][ftail[src]] = mk_flit(src, seq, tail);
    ftail[src]++;
  endtask

  task automatic expect_pkt(input int src, input int len, input int base);
    for (int i = 0; i < len; i++) exp_q.push_back(mk_flit(src, base + i, i == len - 1));
  endtask

  task automatic push_pkt(input int src, input int len, input int base);
    for (int i = 0; i < len; i++) load_flit(src, base + i, i == len - 1);
    expect_pkt(src, len, base);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    gnt_log.delete();
    vld_log.delete();
  endtask

  function automatic int first_read(input int max_f);
    int f;
    f = -1;
    for (int i = 0; i < rd_log.size(); i++)
      if (f < 0 && rd_log[i] != '0) f = i;
    if (f < 0) f = 0;
    if (f > max_f) f = max_f;
    return f;
  endfunction

  function automatic int count_reads(input int bit_sel);
    int c;
    c = 0;
    for (int i = 0; i < rd_log.size(); i++)
      if (bit_sel < 0 ? (rd_log[i] != '0) : rd_log[i][bit_sel]) c++;
    return c;
  endfunction

  // One clock cycle: sample at the falling edge, model the FIFOs at the
  // rising edge (read data appears the cycle after the strobe).
  task automatic step();
    int           rk;
    logic [W-1:0] rf;
    bit           rv;
    rv = 1'b0;
    rk = 0;
    rf = '0;
    @(negedge clk_i);
    check_eq("read_onehot", ($countones(read_o) <= 1), 1);
    for (int k = 0; k < N; k++) begin
      if (read_o[k]) begin
        check_eq("read_nonempty", (fhead[k] != ftail[k]), 1);
        if (fhead[k] != ftail[k]) begin
          rf = fmem[k][fhead[k]];
          fhead[k]++;
          rv = 1'b1;
          rk = k;
        end
      end
    end
    if (valid_o && ready_i) begin
      check_eq("xfer_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("xfer_data", data_o, exp_q.pop_front());
      $display("xfer src=%0d seq=%0d tail=%0b", data_o[23:16], data_o[15:0], data_o[TB]);
    end
    rd_log.push_back(read_o);
    gnt_log.push_back(grant_o);
    vld_log.push_back(valid_o);
    @(posedge clk_i);
    #1;
    if (rv) data_i[rk*W +: W] = rf;
    update_empty();
  endtask

  initial begin
    int f;
    logic [N-1:0] last_g;
    logic [N-1:0] gseq [$];
    logic [N-1:0] pat [9];

    rst_i   = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    for (int k = 0; k < N; k++) begin
      fhead[k] = 0;
      ftail[k] = 0;
    end
    update_empty();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_eq("rst_read", read_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_data", data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single 3-flit packet on input 2.
    clear_logs();
    push_pkt(2, 3, 0);
    update_empty();
    repeat (12) step();
    f = first_read(6);
    for (int i = 0; i < 3; i++) check_eq("t1_read", rd_log[f+i], 4'b0100);
    check_eq("t1_read_stop", rd_log[f+3], 0);
    check_eq("t1_read_count", count_reads(-1), 3);
    check_eq("t1_valid_lat", vld_log[f+1], 0);
    for (int i = 2; i < 5; i++) check_eq("t1_valid", vld_log[f+i], 1);
    check_eq("t1_valid_end", vld_log[f+5], 0);
    check_eq("t1_grant_tail", gnt_log[f+3], 4'b0100);
    check_eq("t1_grant_rel", gnt_log[f+4], 0);
    check_eq("t1_drained", exp_q.size(), 0);

    // rr pointer is now 3: input 3 must beat input 0.
    clear_logs();
    push_pkt(3, 1, 20);
    push_pkt(0, 1, 10);
    update_empty();
    repeat (10) step();
    check_eq("t1b_first_grant", rd_log[first_read(9)], 4'b1000);
    check_eq("t1b_drained", exp_q.size(), 0);

    // Backpressure during a 5-flit packet on input 1 (rr pointer is 1).
    clear_logs();
    ready_i = 1'b0;
    push_pkt(1, 5, 30);
    update_empty();
    repeat (8) step();
    check_eq("t3_reads", count_reads(-1), 2);
    check_eq("t3_read_idle", rd_log[7], 0);
    check_eq("t3_valid", valid_o, 1);
    check_eq("t3_hold_data", data_o, mk_flit(1, 30, 0));
    ready_i = 1'b1;
    repeat (12) step();
    check_eq("t3_drained", exp_q.size(), 0);

    // Input 1 starves after its head flit while input 2 waits.
    expect_pkt(1, 3, 40);
    expect_pkt(2, 2, 50);
    load_flit(1, 40, 1'b0);
    update_empty();
    step();
    load_flit(2, 50, 1'b0);
    load_flit(2, 51, 1'b1);
    update_empty();
    clear_logs();
    repeat (10) step();
    for (int i = 0; i < 10; i++) check_eq("t4_grant_hold", gnt_log[i], 4'b0010);
    check_eq("t4_no_read_in2", count_reads(2), 0);
    check_eq("t4_err", err_o, EXP_ERR);
    load_flit(1, 41, 1'b0);
    load_flit(1, 42, 1'b1);
    update_empty();
    repeat (14) step();
    check_eq("t4_drained", exp_q.size(), 0);
    check_eq("t4_err_sticky", err_o, EXP_ERR);

    // Asynchronous reset mid-packet with a full buffer.
    clear_logs();
    ready_i = 1'b0;
    push_pkt(0, 4, 60);
    update_empty();
    repeat (6) step();
    check_eq("t5_pre_valid", valid_o, 1);
    check_eq("t5_pre_grant", grant_o, 4'b0001);
    #2;
    rst_i = 1'b0;
    #1;
    check_eq("t5_rst_valid", valid_o, 0);
    check_eq("t5_rst_read", read_o, 0);
    check_eq("t5_rst_grant", grant_o, 0);
    check_eq("t5_rst_err", err_o, 0);
    for (int k = 0; k < N; k++) begin
      fhead[k] = 0;
      ftail[k] = 0;
    end
    exp_q.delete();
    update_empty();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Three 2-flit packets at once; order 0, 1, 3 with one bubble each.
    clear_logs();
    ready_i = 1'b1;
    push_pkt(0, 2, 70);
    push_pkt(1, 2, 80);
    push_pkt(3, 2, 90);
    update_empty();
    repeat (14) step();
    pat = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    f = first_read(5);
    for (int i = 0; i < 9; i++) check_eq("t2_read_pat", rd_log[f+i], pat[i]);
    last_g = '0;
    for (int i = 0; i < gnt_log.size(); i++) begin
      if (gnt_log[i] != '0 && gnt_log[i] != last_g) gseq.push_back(gnt_log[i]);
      last_g = gnt_log[i];
    end
    check_eq("t2_grant_count", gseq.size(), 3);
    if (gseq.size() == 3) begin
      check_eq("t2_grant0", gseq[0], 4'b0001);
      check_eq("t2_grant1", gseq[1], 4'b0010);
      check_eq("t2_grant2", gseq[2], 4'b1000);
    end
    check_eq("t2_drained", exp_q.size(), 0);
    check_eq("t2_idle_grant", grant_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Shares one router output link between N input FIFOs (synchronous, 1-cycle registered read data, empty flag).
- Round-robin arbitration with wormhole locking: once an input wins, it keeps the link until its tail flit has been read.
- Issues FIFO read strobes, captures returned flits into a 2-entry output buffer, and presents them on a valid/ready link.

Parameters:
- N, 4, number of input FIFOs (2..16).
- WIDTH, 32, flit width.
- TAIL_BIT, 31, flit bit index; 1 marks the packet tail flit.
- WDOG_CYCLES, 64, watchdog stall limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- empty_i  in  N  per-FIFO empty flags.
- read_o  out  N  per-FIFO read strobes; at most one bit high per cycle.
- data_i  in  N*WIDTH  FIFO read data, slice k = [k*WIDTH +: WIDTH]; valid the cycle after read_o[k].
- data_o  out  WIDTH  output flit (head of the output buffer).
- valid_o  out  1  data_o valid.
- ready_i  in  1  link accepts the flit when valid_o & ready_i.
- grant_o  out  N  one-hot current owner; 0 when idle.
- err_o  out  1  sticky watchdog error; constant 0 without the optional feature.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - read_o=0, valid_o=0, grant_o=0, err_o=0, data_o=0.
  - Output buffer emptied, in-flight flag cleared, rr pointer = 0, state = ARB.
- States: ARB, LOCK.
- ARB:
  - Pick the first k with empty_i[k]=0, searching from rr pointer upward modulo N.
  - If a read slot is free (see credit rule), assert read_o[k], set grant_o=onehot(k), go to LOCK.
  - Otherwise stay in ARB with read_o=0.
- LOCK, owner k:
  - In-flight data_i slice k is examined combinationally in the cycle it is valid.
  - Tail in flight (data_i[k][TAIL_BIT]=1): no new read. Go to ARB, rr pointer = (k+1) mod N, grant_o=0 next cycle. This costs one bubble cycle between packets.
  - Otherwise, read_o[k] asserts whenever empty_i[k]=0 and a slot is free, giving back-to-back reads within a packet.
  - empty_i[k]=1 mid-packet: hold LOCK, issue no read, grant is not released.
- Credit rule (the buffer never overflows):
  - used = buffer occupancy + in-flight read (0/1) − (valid_o & ready_i).
  - A read may issue only when used < 2.
- Data capture:
  - The flit read at cycle t is written into the buffer at the end of cycle t+1.
  - Empty-to-valid_o latency is 2 cycles after read_o.
  - FIFO order is preserved; simultaneous push and pop are allowed.
- Output link:
  - valid_o = buffer not empty.
  - data_o and valid_o stay stable while valid_o & ~ready_i.
- A read is never issued to an input whose empty_i is high. Empty flags of non-owners are ignored in LOCK.

Optional Feature:
- ARB_WATCHDOG_EN defined:
  - A counter runs in LOCK while empty_i[owner]=1 and no flit is in flight; it clears on any read.
  - When the count reaches WDOG_CYCLES, err_o goes to 1 and stays 1 until reset. Arbitration is unaffected.
- Not defined: no counter logic; err_o tied to 0.

Test Plan:
- Single 3-flit packet on input 2, ready_i=1:
  - read_o=4'b0100 for 3 consecutive cycles.
  - valid_o high for 3 cycles, starting 2 cycles after the first read.
  - grant_o returns to 0 after the tail; rr pointer becomes 3.
- Inputs 0, 1 and 3 each hold one 2-flit packet, all non-empty at once: grants in order 0, 1, 3, packets not interleaved, one idle cycle between packets.
- Backpressure: ready_i=0 during a 5-flit packet.
  - Exactly 2 reads issued, then read_o=0.
  - data_o holds the first flit.
  - Releasing ready_i drains all 5 flits in order.
- Input 1 goes empty after the head flit for 10 cycles, while input 2 is non-empty:
  - grant_o stays 4'b0010 and input 2 is never read.
  - The packet then completes.
- Asynchronous reset asserted mid-packet with the buffer holding 2 flits: valid_o, read_o and grant_o go to 0 immediately; after release, arbitration restarts from input 0.
- ARB_WATCHDOG_EN with WDOG_CYCLES=8: owner empty for 8 cycles mid-packet sets err_o=1, and it stays 1 after traffic resumes.
